// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation codes, ALUOp encodings and issue entry type
package alu_pkg;
    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_AND     = 4'b0000;
    localparam alu_op_t ALU_OR      = 4'b0001;
    localparam alu_op_t ALU_ADD     = 4'b0010;
    localparam alu_op_t ALU_SUB     = 4'b0110;
    localparam alu_op_t ALU_EQ      = 4'b1000;
    localparam alu_op_t ALU_ILLEGAL = 4'b1111;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    typedef struct packed {
        logic [31:0] SrcA;
        logic [31:0] SrcB;
        alu_op_t     Operation;
        logic        illegal;
    } issue_entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;
endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational {ALUOp, Funct3, Funct7} to ALU Operation decode
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] Funct3,
    input  logic [6:0] Funct7,
    output alu_op_t    Operation,
    output logic       illegal
);
    always_comb begin
        Operation = ALU_ILLEGAL;
        case (ALUOp)
            ALUOP_MEM: Operation = ALU_ADD;
            ALUOP_BR: begin
                if (Funct3 == 3'b000) Operation = ALU_EQ;
            end
            ALUOP_R: begin
                if (Funct3 == 3'b000 && Funct7 == 7'b0000000)      Operation = ALU_ADD;
                else if (Funct3 == 3'b000 && Funct7 == 7'b0100000) Operation = ALU_SUB;
                else if (Funct3 == 3'b111 && Funct7 == 7'b0000000) Operation = ALU_AND;
                else if (Funct3 == 3'b110 && Funct7 == 7'b0000000) Operation = ALU_OR;
            end
            default: begin
                // I-type arithmetic: Funct7 carries immediate bits, so it is not examined
                case (Funct3)
                    3'b000:  Operation = ALU_ADD;
                    3'b111:  Operation = ALU_AND;
                    3'b110:  Operation = ALU_OR;
                    default: Operation = ALU_ILLEGAL;
                endcase
            end
        endcase
    end

    assign illegal = (Operation == ALU_ILLEGAL);
endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - registered ALU issue stage with 2-entry skid buffer
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               ALUOp,
    input  logic [2:0]               Funct3,
    input  logic [6:0]               Funct7,
    input  logic [DATA_WIDTH-1:0]    in_SrcA,
    input  logic [DATA_WIDTH-1:0]    in_SrcB,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     illegal_op
);
    skid_state_t state, state_next;

    alu_op_t dec_op;
    logic    dec_illegal;

    logic [DATA_WIDTH-1:0]    m_a, m_b, s_a, s_b;
    logic [OPCODE_LENGTH-1:0] m_op, s_op;
    logic                     m_ill, s_ill;

    logic accept, issue, load_m, load_s, move_s;

    alu_op_decode u_decode (
        .ALUOp     (ALUOp),
        .Funct3    (Funct3),
        .Funct7    (Funct7),
        .Operation (dec_op),
        .illegal   (dec_illegal)
    );

    assign accept = in_valid && in_ready;
    assign issue  = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_EMPTY;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: if (accept) state_next = ST_ONE;
            ST_ONE: begin
                if (accept && !issue)      state_next = ST_TWO;
                else if (!accept && issue) state_next = ST_EMPTY;
            end
            ST_TWO:   if (issue) state_next = ST_ONE;
            default:  state_next = ST_EMPTY;
        endcase
        // Flush wins over any concurrent accept; a concurrent issue has already left
        if (flush) state_next = ST_EMPTY;
    end

    always_comb begin
        in_ready  = (state != ST_TWO);
        out_valid = (state != ST_EMPTY);
        load_m    = accept && ((state == ST_EMPTY) || issue);
        load_s    = accept && (state == ST_ONE) && !issue;
        move_s    = issue && (state == ST_TWO);
    end

    // Data registers hold their contents across flush; only the valid state is cleared
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_a   <= '0;
            m_b   <= '0;
            m_op  <= '0;
            m_ill <= 1'b0;
            s_a   <= '0;
            s_b   <= '0;
            s_op  <= '0;
            s_ill <= 1'b0;
        end else begin
            if (load_m) begin
                m_a   <= in_SrcA;
                m_b   <= in_SrcB;
                m_op  <= dec_op;
                m_ill <= dec_illegal;
            end else if (move_s) begin
                m_a   <= s_a;
                m_b   <= s_b;
                m_op  <= s_op;
                m_ill <= s_ill;
            end
            if (load_s) begin
                s_a   <= in_SrcA;
                s_b   <= in_SrcB;
                s_op  <= dec_op;
                s_ill <= dec_illegal;
            end
        end
    end

    assign SrcA       = m_a;
    assign SrcB       = m_b;
    assign Operation  = m_op;
    assign illegal_op = m_ill;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard testbench for alu_issue_stage
module tb_alu_issue_stage;
    logic        clk, reset, flush, in_valid, in_ready, out_valid, out_ready, illegal_op;
    logic [1:0]  ALUOp;
    logic [2:0]  Funct3;
    logic [6:0]  Funct7;
    logic [31:0] in_SrcA, in_SrcB, SrcA, SrcB;
    logic [3:0]  Operation;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    logic [3:0]  exp_op;
    logic        exp_ill;
    int          checks = 0;
    int          errors = 0;

    alu_issue_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .Funct3(Funct3), .Funct7(Funct7),
        .in_SrcA(in_SrcA), .in_SrcB(in_SrcB),
        .out_valid(out_valid), .out_ready(out_ready),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected entries are recorded on accept from the stimulus-side hand values
    always @(posedge clk or posedge reset) begin
        if (reset)                      q.delete();
        else if (flush)                 q.delete();
        else if (in_valid && in_ready)  q.push_back({in_SrcA, in_SrcB, exp_op, exp_ill});
    end

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            check("sb_nonempty", (q.size() != 0), 1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                check("out_SrcA", SrcA, e.a);
                check("out_SrcB", SrcB, e.b);
                check("out_Operation", Operation, e.op);
                check("out_illegal", illegal_op, e.ill);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] eop, input logic eill);
        int n;
        ALUOp = op; Funct3 = f3; Funct7 = f7; in_SrcA = a; in_SrcB = b;
        exp_op = eop; exp_ill = eill;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("drive_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ALUOp = '0; Funct3 = '0; Funct7 = '0; in_SrcA = '0; in_SrcB = '0;
        exp_op = '0; exp_ill = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_SrcA", SrcA, 0);
        check("rst_SrcB", SrcB, 0);
        check("rst_Operation", Operation, 0);
        check("rst_illegal", illegal_op, 0);

        // Decode sweep
        out_ready = 1'b1;
        drive(2'b10, 3'b000, 7'b0100000, 32'd7, 32'd3, 4'b0110, 1'b0);
        @(negedge clk);
        check("latency_out_valid", out_valid, 1);
        drive(2'b10, 3'b001, 7'b0000000, 32'd1, 32'd2, 4'b1111, 1'b1);
        drive(2'b10, 3'b000, 7'b0000000, 32'd10, 32'd20, 4'b0010, 1'b0);
        drive(2'b10, 3'b111, 7'b0000000, 32'hF0, 32'h3C, 4'b0000, 1'b0);
        drive(2'b10, 3'b110, 7'b0000000, 32'hA, 32'h5, 4'b0001, 1'b0);
        drive(2'b10, 3'b111, 7'b0100000, 32'h1, 32'h1, 4'b1111, 1'b1);
        drive(2'b00, 3'b101, 7'b1111111, 32'h100, 32'h4, 4'b0010, 1'b0);
        drive(2'b11, 3'b000, 7'b1010101, 32'h9, 32'hFFF, 4'b0010, 1'b0);
        drive(2'b11, 3'b111, 7'b0000000, 32'h77, 32'hF, 4'b0000, 1'b0);
        drive(2'b11, 3'b110, 7'b0100000, 32'h80, 32'h1, 4'b0001, 1'b0);
        drive(2'b11, 3'b010, 7'b0000000, 32'h2, 32'h3, 4'b1111, 1'b1);
        drive(2'b01, 3'b000, 7'b0000000, 32'h55, 32'h55, 4'b1000, 1'b0);
        drive(2'b01, 3'b001, 7'b0000000, 32'h55, 32'h56, 4'b1111, 1'b1);
        idle(2);

        // Back-pressure: X then Y held, then drained in order
        out_ready = 1'b0;
        drive(2'b00, 3'b000, 7'b0, 32'd100, 32'd101, 4'b0010, 1'b0);
        drive(2'b10, 3'b000, 7'b0100000, 32'd200, 32'd201, 4'b0110, 1'b0);
        check("bp_in_ready_low", in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_SrcA", SrcA, 32'd100);
            check("bp_hold_op", Operation, 4'b0010);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_back", in_ready, 1);
        check("bp_second_SrcA", SrcA, 32'd200);
        idle(2);
        check("bp_drained", out_valid, 0);

        // Streaming: no bubbles once the first entry lands
        fork
            for (int i = 0; i < 16; i++)
                drive(2'b00, 3'b000, 7'b0, i, i + 1, 4'b0010, 1'b0);
            begin
                @(negedge clk);
                for (int k = 0; k < 16; k++) begin
                    @(negedge clk);
                    check("stream_no_bubble", out_valid, 1);
                end
            end
        join
        idle(2);

        // Flush while holding two entries with a new one offered
        out_ready = 1'b0;
        drive(2'b00, 3'b000, 7'b0, 32'h111, 32'h0, 4'b0010, 1'b0);
        drive(2'b00, 3'b000, 7'b0, 32'h222, 32'h0, 4'b0010, 1'b0);
        in_SrcA = 32'h333; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        idle(3);

        // Flush coinciding with issue and accept: issued entry counts, new one dropped
        drive(2'b11, 3'b111, 7'b0, 32'h444, 32'h5, 4'b0000, 1'b0);
        in_SrcA = 32'h555; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        check("flush2_out_valid", out_valid, 0);
        idle(3);

        // Asynchronous reset between clock edges
        out_ready = 1'b0;
        drive(2'b10, 3'b000, 7'b0100000, 32'hABC, 32'hDEF, 4'b0110, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_SrcA", SrcA, 0);
        check("arst_SrcB", SrcB, 0);
        check("arst_Operation", Operation, 0);
        check("arst_illegal", illegal_op, 0);
        check("arst_in_ready", in_ready, 1);
        @(posedge clk);
        #1 reset = 1'b0;

        // Branch compare
        out_ready = 1'b1;
        drive(2'b01, 3'b000, 7'b0, 32'h55, 32'h55, 4'b1000, 1'b0);
        @(negedge clk);
        check("br_Operation", Operation, 4'b1000);
        idle(3);
        check("sb_empty_end", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Registered issue stage between decode and the datapath ALU.
- Accepts decoded ALU control fields plus two operands over a valid/ready handshake.
- Translates the control fields into the ALU's 4-bit Operation code.
- Presents SrcA, SrcB and Operation from registers; a 2-entry skid buffer gives full throughput with a registered in_ready.

Parameters:
DATA_WIDTH, 32, operand width
OPCODE_LENGTH, 4, width of the ALU Operation code

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous pipeline flush (branch taken / exception)
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept; registered
ALUOp  input  2  00 load/store, 01 branch, 10 R-type, 11 I-type arith
Funct3  input  3  instruction funct3
Funct7  input  7  instruction funct7
in_SrcA  input  DATA_WIDTH  operand A
in_SrcB  input  DATA_WIDTH  operand B (register or immediate, selected upstream)
out_valid  output  1  SrcA/SrcB/Operation valid
out_ready  input  1  downstream (EX/MEM) accepts
SrcA  output  DATA_WIDTH  to ALU
SrcB  output  DATA_WIDTH  to ALU
Operation  output  OPCODE_LENGTH  to ALU
illegal_op  output  1  qualified by out_valid; unsupported ALUOp/Funct combination

Behaviour:
- Reset: all outputs 0; in_ready=1; both entries empty. Reset asserted mid-transfer discards everything.
- Decode is combinational on the input side and the result is registered with the operands:
  - ALUOp=00 -> ADD 0010.
  - ALUOp=01 -> EQUAL 1000 when Funct3=000; otherwise illegal.
  - ALUOp=10 (R-type):
    - Funct3=000 and Funct7=0000000 -> ADD 0010.
    - Funct3=000 and Funct7=0100000 -> SUB 0110.
    - Funct3=111 and Funct7=0 -> AND 0000.
    - Funct3=110 and Funct7=0 -> OR 0001.
    - Anything else -> illegal.
  - ALUOp=11 (I-type): Funct7 is ignored.
    - Funct3=000 -> ADD.
    - Funct3=111 -> AND.
    - Funct3=110 -> OR.
    - Anything else -> illegal.
  - Illegal: Operation=1111 (the ALU yields 0) and illegal_op=1.
- Storage: main register M (drives outputs) and skid register S; states EMPTY, ONE (M valid), TWO (M and S valid).
- Accept = in_valid & in_ready. Issue = out_valid & out_ready.
- in_ready = !S_valid, registered.
- out_valid = M_valid.
- EMPTY:
  - Accept -> ONE, M loaded. Latency: input to output is 1 cycle.
- ONE:
  - Accept with issue -> ONE, M reloaded.
  - Accept without issue -> TWO, new entry into S.
  - Issue only -> EMPTY.
- TWO (in_ready=0):
  - Issue -> ONE, S moves to M.
- Ordering is strict FIFO; an entry is never dropped or duplicated.
- Outputs hold stable while out_valid=1 and out_ready=0.
- flush=1:
  - Next state is EMPTY and in_ready=1.
  - flush has priority over a simultaneous accept or issue; that accepted entry is discarded.
  - An issue in the flush cycle still counts as transferred downstream.
- Data registers are not cleared by flush; only the valid bits are. Downstream must qualify on out_valid.
- Width: operands pass through unmodified; no arithmetic in this block.

Decomposition:
- Shared package alu_pkg:
  - typedef alu_op_t, logic [3:0].
  - Constants ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_EQ=1000, ALU_ILLEGAL=1111.
  - ALUOp encodings ALUOP_MEM, ALUOP_BR, ALUOP_R, ALUOP_I.
  - Struct issue_entry_t: SrcA, SrcB, Operation, illegal.
- Sub-module alu_op_decode: combinational {ALUOp, Funct3, Funct7} -> {Operation, illegal}. The same function is reusable by other decoders.
- The skid logic stays in this module.

Test Plan:
- Decode sweep:
  - ALUOp=10, Funct3=000, Funct7=0100000, A=7, B=3 -> one cycle later out_valid=1, Operation=0110, SrcA=7, SrcB=3, illegal_op=0.
  - ALUOp=10, Funct3=001 -> Operation=1111, illegal_op=1.
- Back-pressure:
  - Accept X, then Y, with out_ready=0 -> in_ready falls after Y.
  - Outputs hold X for 5 cycles.
  - Raise out_ready -> X, then Y on consecutive cycles; in_ready returns to 1.
- Streaming:
  - in_valid=out_ready=1 for 16 cycles with incrementing SrcA 0..15 -> outputs 0..15 in order, no bubbles after the first cycle.
- Flush in TWO state with in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed entries never appear downstream.
- Reset asserted asynchronously mid-stream (between clock edges) -> out_valid, SrcA, SrcB, Operation, illegal_op go to 0 immediately; in_ready=1.
- Branch: ALUOp=01, Funct3=000, A=B=0x55 -> Operation=1000, illegal_op=0.
